i2s_rx_core: RTL and testbench

//  I2S master receiver, the receive-side counterpart of the I2S transmitter core.

---
 rtl/i2s_rx_core.sv | 172 +++++++++++++++++
 tb/tb_i2s_rx_core.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_core.sv
// i2s_rx_core
//   I2S master receiver. Divides aud_mclk down to the I2S bit clock (sclk_out)
//   and word select (lrclk_out). It deserialises sdata_in (MSB first, one SCLK
//   of data delay after each word-select change) into left/right samples,
//   queues them in a small FIFO and presents them on an AXI4-Stream master.
//
// Ports
//   aud_mclk       single clock for the whole block
//   aud_mresetn    asynchronous active-low reset
//   enable         1 = generate clocks and capture, 0 = idle (FIFO keeps draining)
//   sclk_out       I2S bit clock, period 2*SCLK_DIVIDER_VALUE mclk cycles
//   lrclk_out      I2S word select, 0 = left, 1 = right
//   sdata_in       I2S serial data, already synchronous to aud_mclk
//   m_axis_tdata   sample placed at [AUD_WIDTH+3:4], all other bits zero
//   m_axis_tid     channel of the sample, 0 = left, 1 = right
//   m_axis_tvalid  FIFO not empty
//   m_axis_tready  downstream ready
//   overflow       sticky flag: a sample was dropped on a full FIFO
//   fifo_level     current FIFO occupancy
module i2s_rx_core #(
  parameter int AUD_WIDTH             = 24,
  parameter int AXI_STREAM_DATA_WIDTH = 32,
  parameter int AXI_STREAM_TID_WIDTH  = 3,
  parameter int SCLK_DIVIDER_VALUE    = 4,
  parameter int FIFO_DEPTH            = 16
) (
  input  logic                               aud_mclk,
  input  logic                               aud_mresetn,
  input  logic                               enable,
  output logic                               sclk_out,
  output logic                               lrclk_out,
  input  logic                               sdata_in,
  output logic [AXI_STREAM_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXI_STREAM_TID_WIDTH-1:0]    m_axis_tid,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

  localparam int DIV_W = (SCLK_DIVIDER_VALUE > 1) ? $clog2(SCLK_DIVIDER_VALUE) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIVIDER_VALUE - 1);
  localparam logic [4:0]       LSB_POS    = 5'(AUD_WIDTH);
  localparam logic [PTR_W:0]   DEPTH_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  // Clock generation and frame position
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic             div_tc;
  logic             sclk_rise;
  logic [4:0]       slot_pos;

  // Deserialiser and the one-cycle push stage
  logic [AUD_WIDTH-1:0] shift_reg;
  logic                 push_pend;
  logic [AUD_WIDTH-1:0] push_sample;
  logic                 push_tid;
  logic                 capture_bit;

  // Sample FIFO; one extra pointer bit tells full from empty
  logic [AUD_WIDTH:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic [AUD_WIDTH:0] head_entry;
  logic               fifo_empty;
  logic               fifo_full;
  logic               do_push;
  logic               do_pop;

  assign div_tc    = (div_cnt == DIV_LAST);
  assign sclk_rise = enable && div_tc && !sclk_out;
  assign slot_pos  = bit_cnt[4:0];
  assign lrclk_out = bit_cnt[5];

  // Slot position 0 is the I2S delay bit; positions past the LSB are padding.
  assign capture_bit = sclk_rise && (slot_pos != 5'd0) && (slot_pos <= LSB_POS);

  // Divider, bit clock and frame counter. The frame counter advances on the
  // falling toggle so word select changes on SCLK falling edges only.
  always_ff @(posedge aud_mclk or negedge aud_mresetn) begin
    if (!aud_mresetn) begin
      div_cnt  <= '0;
      sclk_out <= 1'b0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      div_cnt  <= '0;
      sclk_out <= 1'b0;
      bit_cnt  <= '0;
    end else if (div_tc) begin
      div_cnt  <= '0;
      sclk_out <= !sclk_out;
      if (sclk_out) begin
        bit_cnt <= bit_cnt + 6'd1;
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Shift in MSB..LSB; the completed word waits one cycle in the push stage
  // before entering the FIFO.
  always_ff @(posedge aud_mclk or negedge aud_mresetn) begin
    if (!aud_mresetn) begin
      shift_reg   <= '0;
      push_pend   <= 1'b0;
      push_sample <= '0;
      push_tid    <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      if (!enable) begin
        shift_reg <= '0;
      end else if (capture_bit) begin
        shift_reg <= {shift_reg[AUD_WIDTH-2:0], sdata_in};
        if (slot_pos == LSB_POS) begin
          push_pend   <= 1'b1;
          push_sample <= {shift_reg[AUD_WIDTH-2:0], sdata_in};
          push_tid    <= lrclk_out;
        end
      end
    end
  end

  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fifo_level == DEPTH_FULL);
  assign do_pop     = !fifo_empty && m_axis_tready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = push_pend && (!fifo_full || do_pop);

  always_ff @(posedge aud_mclk) begin
    if (do_push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= {push_tid, push_sample};
    end
  end

  // Pointers and the sticky overflow flag; disabling the receiver clears it.
  always_ff @(posedge aud_mclk or negedge aud_mresetn) begin
    if (!aud_mresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
      end
      if (!enable) begin
        overflow <= 1'b0;
      end else if (push_pend && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

  assign head_entry    = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign m_axis_tvalid = !fifo_empty;

  // Output word is zero whenever the FIFO is empty, so reset shows all zeros.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tid   = '0;
    if (!fifo_empty) begin
      m_axis_tdata[AUD_WIDTH+3:4] = head_entry[AUD_WIDTH-1:0];
      m_axis_tid[0]               = head_entry[AUD_WIDTH];
    end
  end

endmodule

// File: tb/tb_i2s_rx_core.sv
// tb_i2s_rx_core
//   Bench for i2s_rx_core. An I2S source model follows the DUT's clocks and
//   drives serial words; a queue-based model of the receive FIFO predicts
//   tvalid/tdata/tid/fifo_level/overflow every cycle. A second instance with
//   16-bit samples and a divider of 1 covers the narrow configuration.
module tb_i2s_rx_core;

  localparam int W     = 24;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  id;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sdata = 1'b0;
  logic        tready = 1'b0;
  logic        sclk, lrclk, tvalid, ovf;
  logic [31:0] tdata;
  logic [2:0]  tid;
  logic [4:0]  level;

  logic        en16 = 1'b0;
  logic        sdata16 = 1'b0;
  logic        tready16 = 1'b1;
  logic        sclk16, lr16, tvalid16, ovf16;
  logic [31:0] tdata16;
  logic [2:0]  tid16;
  logic [2:0]  level16;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  item_t       exp_q[$];
  item_t       act_log[$];
  logic        exp_ovf = 1'b0;
  logic        pend = 1'b0;
  item_t       pend_item;
  int          pushes_seen = 0;
  logic        last_valid = 1'b0;
  item_t       last_out;

  // Source model state
  int          src_p = 0;
  logic [23:0] src_word = '0;
  logic        prev_sclk = 1'b0;
  logic        prev_lr = 1'b0;
  int          src_mode = 1;
  logic [23:0] ramp_next = '0;

  int          s16_p = 0;
  logic [15:0] s16_word = '0;
  logic        s16_prev_sclk = 1'b0;
  logic        s16_prev_lr = 1'b0;

  i2s_rx_core dut (
    .aud_mclk(clk), .aud_mresetn(rst_n), .enable(enable),
    .sclk_out(sclk), .lrclk_out(lrclk), .sdata_in(sdata),
    .m_axis_tdata(tdata), .m_axis_tid(tid), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .overflow(ovf), .fifo_level(level)
  );

  i2s_rx_core #(.AUD_WIDTH(16), .SCLK_DIVIDER_VALUE(1), .FIFO_DEPTH(4)) dut16 (
    .aud_mclk(clk), .aud_mresetn(rst_n), .enable(en16),
    .sclk_out(sclk16), .lrclk_out(lr16), .sdata_in(sdata16),
    .m_axis_tdata(tdata16), .m_axis_tid(tid16), .m_axis_tvalid(tvalid16),
    .m_axis_tready(tready16), .overflow(ovf16), .fifo_level(level16)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkBound(input string name, input int waited, input int limit, input bit ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL %s: waited %0d cycles, limit %0d, condition not reached", name, waited, limit);
    end
  endtask

  task automatic checkLog(input string name, input int idx, input logic [31:0] data, input logic [2:0] id);
    if (idx >= act_log.size()) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s: delivered %0d samples, expected sample index %0d", name, act_log.size(), idx);
    end else begin
      checkOutput({name, "_tdata"}, act_log[idx].data, data);
      checkOutput({name, "_tid"}, 32'(act_log[idx].id), 32'(id));
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    @(negedge clk);
    enable = en;
    tready = rdy;
  endtask

  task automatic waitPops(input int target, input int limit);
    int c = 0;
    while (act_log.size() < target && c < limit) begin
      @(negedge clk);
      c++;
    end
    checkBound("wait_pops", c, limit, act_log.size() >= target);
  endtask

  task automatic waitPushes(input int target, input int limit);
    int c = 0;
    while (pushes_seen < target && c < limit) begin
      @(negedge clk);
      c++;
    end
    checkBound("wait_pushes", c, limit, pushes_seen >= target);
  endtask

  task automatic waitDrain(input int limit);
    int c = 0;
    while ((exp_q.size() != 0 || tvalid) && c < limit) begin
      @(negedge clk);
      c++;
    end
    checkBound("wait_drain", c, limit, exp_q.size() == 0 && !tvalid);
  endtask

  task automatic measurePeriod(input string name, input bit use_lr, input int expected, input int limit);
    int   t0 = -1;
    int   period = -1;
    logic prv = use_lr ? lrclk : sclk;
    logic cur;
    for (int c = 0; c < limit && period < 0; c++) begin
      @(negedge clk);
      cur = use_lr ? lrclk : sclk;
      if (cur && !prv) begin
        if (t0 < 0) t0 = c;
        else period = c - t0;
      end
      prv = cur;
    end
    checkOutput(name, 32'(period), 32'(expected));
  endtask

  // Receive model plus I2S source. At the clock edge the model applies the
  // pop (tready with a non-empty queue) before the pending push, so a full
  // queue that is drained in the same cycle still accepts the word. Just after
  // the edge the source reacts to SCLK: a rise while the LSB is on the line
  // completes a word, a fall moves to the next bit position.
  always @(posedge clk) begin : model
    bit mpop;
    bit drop;
    if (!rst_n) begin
      exp_q.delete();
      exp_ovf   = 1'b0;
      pend      = 1'b0;
      src_p     = 0;
      prev_sclk = 1'b0;
      prev_lr   = 1'b0;
      sdata     = 1'b0;
    end else begin
      if (last_valid && tready) act_log.push_back(last_out);
      mpop = (exp_q.size() > 0) && tready;
      drop = pend && (exp_q.size() == DEPTH) && !mpop;
      if (mpop) void'(exp_q.pop_front());
      if (pend && !drop) exp_q.push_back(pend_item);
      if (drop) exp_ovf = 1'b1;
      if (!enable) exp_ovf = 1'b0;
      pend = 1'b0;
      #1;
      if (!enable) begin
        src_p = 0;
        sdata = 1'b0;
      end else if (sclk && !prev_sclk) begin
        if (src_p == W) begin
          pend           = 1'b1;
          pend_item.data = 32'(src_word) * 32'd16;
          pend_item.id   = 3'(lrclk);
          pushes_seen++;
        end
      end else if (!sclk && prev_sclk) begin
        if (lrclk != prev_lr) src_p = 0;
        else src_p++;
        if (src_p == 1) begin
          if (src_mode == 0) begin
            src_word = lrclk ? 24'h5A5A5A : 24'hA5A5A5;
          end else begin
            src_word  = ramp_next;
            ramp_next = ramp_next + 24'd1;
          end
        end
        sdata = (src_p >= 1 && src_p <= W) ? src_word[W - src_p] : 1'b1;
      end
      prev_sclk = sclk;
      prev_lr   = lrclk;
    end
  end

  // Source for the narrow instance: fixed L=0x8001, R=0x1234.
  always @(posedge clk) begin : src16
    if (!rst_n || !en16) begin
      s16_p         = 0;
      s16_prev_sclk = 1'b0;
      s16_prev_lr   = 1'b0;
      sdata16       = 1'b0;
    end else begin
      #1;
      if (!sclk16 && s16_prev_sclk) begin
        if (lr16 != s16_prev_lr) s16_p = 0;
        else s16_p++;
        if (s16_p == 1) s16_word = lr16 ? 16'h1234 : 16'h8001;
        sdata16 = (s16_p >= 1 && s16_p <= 16) ? s16_word[16 - s16_p] : 1'b1;
      end
      s16_prev_sclk = sclk16;
      s16_prev_lr   = lr16;
    end
  end

  // Every-cycle comparison of the main instance against the model.
  always @(negedge clk) begin : compare
    if (!rst_n) begin
      last_valid = 1'b0;
    end else begin
      checkOutput("tvalid", 32'(tvalid), 32'(exp_q.size() > 0));
      checkOutput("fifo_level", 32'(level), 32'(exp_q.size()));
      checkOutput("overflow", 32'(ovf), 32'(exp_ovf));
      if (exp_q.size() > 0) begin
        checkOutput("tdata", tdata, exp_q[0].data);
        checkOutput("tid", 32'(tid), 32'(exp_q[0].id));
      end
      last_valid    = tvalid;
      last_out.data = tdata;
      last_out.id   = tid;
    end
  end

  initial begin : stimulus
    int          l0;
    int          p0;
    int          found;
    logic [23:0] rn;
    item_t       got16[$];

    ramp_next = 24'h111111;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_sclk", 32'(sclk), 32'd0);
    checkOutput("reset_lrclk", 32'(lrclk), 32'd0);
    checkOutput("reset_tvalid", 32'(tvalid), 32'd0);
    checkOutput("reset_tdata", tdata, 32'd0);
    checkOutput("reset_tid", 32'(tid), 32'd0);
    checkOutput("reset_overflow", 32'(ovf), 32'd0);
    checkOutput("reset_level", 32'(level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a frame
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b1);
    repeat (300) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_sclk", 32'(sclk), 32'd0);
    checkOutput("midreset_lrclk", 32'(lrclk), 32'd0);
    checkOutput("midreset_tvalid", 32'(tvalid), 32'd0);
    checkOutput("midreset_tdata", tdata, 32'd0);
    checkOutput("midreset_tid", 32'(tid), 32'd0);
    checkOutput("midreset_overflow", 32'(ovf), 32'd0);
    checkOutput("midreset_level", 32'(level), 32'd0);
    repeat (2) @(negedge clk);
    rn = ramp_next;
    l0 = act_log.size();
    rst_n = 1'b1;
    waitPops(l0 + 1, 700);
    checkLog("after_reset_first", l0, 32'(rn) * 32'd16, 3'd0);

    // Fixed pattern, timing of SCLK and LRCLK
    $display("[TB] fixed pattern");
    applyStimulus(1'b0, 1'b1);
    waitDrain(100);
    src_mode = 0;
    l0 = act_log.size();
    applyStimulus(1'b1, 1'b1);
    waitPops(l0 + 2, 800);
    checkLog("fixed_left", l0, 32'h0A5A5A50, 3'd0);
    checkLog("fixed_right", l0 + 1, 32'h05A5A5A0, 3'd1);
    measurePeriod("sclk_period", 1'b0, 8, 40);
    measurePeriod("frame_period", 1'b1, 512, 1200);

    // Random backpressure with ramp data
    $display("[TB] random backpressure");
    applyStimulus(1'b0, 1'b1);
    waitDrain(100);
    src_mode  = 1;
    ramp_next = 24'h000100;
    l0 = act_log.size();
    p0 = pushes_seen;
    applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 60 * 512; c++) begin
      @(negedge clk);
      tready = ($urandom_range(0, 3) == 0);
    end
    applyStimulus(1'b0, 1'b1);
    waitDrain(200);
    checkOutput("random_no_loss", 32'(act_log.size() - l0), 32'(pushes_seen - p0));
    checkLog("random_first", l0, 32'h00001000, 3'd0);

    // FIFO overflow
    $display("[TB] overflow");
    ramp_next = 24'h100000;
    l0 = act_log.size();
    p0 = pushes_seen;
    applyStimulus(1'b1, 1'b0);
    waitPushes(p0 + 20, 6000);
    repeat (3) @(negedge clk);
    checkOutput("full_level", 32'(level), 32'd16);
    checkOutput("full_overflow", 32'(ovf), 32'd1);
    applyStimulus(1'b1, 1'b1);
    waitPops(l0 + 17, 1200);
    checkLog("ovf_first", l0, 32'h01000000, 3'd0);
    checkLog("ovf_16th", l0 + 15, 32'h010000F0, 3'd1);
    checkLog("ovf_after_loss", l0 + 16, 32'h01000140, 3'd0);

    // Disable at p=10 of a left slot
    $display("[TB] disable mid-word");
    found = 0;
    for (int c = 0; c < 1200 && found == 0; c++) begin
      @(negedge clk);
      if (src_p == 10 && !lrclk) found = 1;
    end
    checkBound("find_p10", 1200, 1200, found == 1);
    checkOutput("pre_disable_overflow", 32'(ovf), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("disabled_sclk", 32'(sclk), 32'd0);
    checkOutput("disabled_lrclk", 32'(lrclk), 32'd0);
    checkOutput("disabled_overflow", 32'(ovf), 32'd0);
    repeat (10) @(negedge clk);
    rn = ramp_next;
    l0 = act_log.size();
    enable = 1'b1;
    waitPops(l0 + 2, 800);
    checkLog("reenable_first", l0, 32'(rn) * 32'd16, 3'd0);
    checkLog("reenable_second", l0 + 1, 32'(rn + 24'd1) * 32'd16, 3'd1);

    // Narrow instance: 16-bit samples, SCLK toggles every mclk
    $display("[TB] 16-bit, divider 1");
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    en16 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("sclk16_toggle", 32'(sclk16), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    for (int c = 0; c < 400 && got16.size() < 2; c++) begin
      @(negedge clk);
      if (tvalid16) got16.push_back('{data: tdata16, id: tid16});
    end
    checkBound("wait_16bit", 400, 400, got16.size() >= 2);
    if (got16.size() >= 2) begin
      checkOutput("w16_left_tdata", got16[0].data, 32'h00080010);
      checkOutput("w16_left_tid", 32'(got16[0].id), 32'd0);
      checkOutput("w16_right_tdata", got16[1].data, 32'h00012340);
      checkOutput("w16_right_tid", 32'(got16[1].id), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
